pid_tx_block: RTL

//   Transmit-side PID encoder/serializer for the Serial Interface Engine; the counterpart of the receive-side PID decoder.

---
 rtl/pid_pkg.sv | 41 ++++
 rtl/pid_tx_piso.sv | 36 +++
 rtl/pid_tx_block.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pid_pkg.sv
// Shared PID definitions for the SIE transmit encoder and receive decoder.
// Holds packet-type codes, the twelve PID nibbles, transmit FSM states and the byte builder.
package pid_pkg;

  localparam int unsigned PID_W     = 8;
  localparam int unsigned PID_CNT_W = 4;

  localparam logic [1:0] PKT_ILLEGAL   = 2'b00;
  localparam logic [1:0] PKT_TOKEN     = 2'b01;
  localparam logic [1:0] PKT_HANDSHAKE = 2'b10;
  localparam logic [1:0] PKT_DATA      = 2'b11;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA2 = 4'b0111;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_MDATA = 4'b1111;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NYET  = 4'b0110;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND_PID = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_DONE     = 2'd3
  } pid_tx_state_e;

  // Wire byte: check nibble (inverted PID) above the PID nibble.
  function automatic logic [PID_W-1:0] pid_byte(input logic [1:0] pkt_type,
                                                input logic [1:0] pid_sel);
    logic [3:0] pid;
    pid = {pid_sel, pkt_type};
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/pid_tx_piso.sv
// 8-bit parallel-load, LSB-first shift register for the PID byte.
// o_last marks the final bit still held; o_empty means nothing left to shift.
module pid_tx_piso
  import pid_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [PID_W-1:0] i_data,
  output logic             o_bit,
  output logic             o_last,
  output logic             o_empty
);

  logic [PID_W-1:0]     r_shift;
  logic [PID_CNT_W-1:0] r_left;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shift <= '0;
      r_left  <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_left  <= PID_CNT_W'(PID_W);
    end else if (i_shift && (r_left != '0)) begin
      r_shift <= {1'b0, r_shift[PID_W-1:1]};
      r_left  <= r_left - PID_CNT_W'(1);
    end
  end

  assign o_bit   = r_shift[0];
  assign o_last  = (r_left == PID_CNT_W'(1));
  assign o_empty = (r_left == '0);

endmodule

// File: rtl/pid_tx_block.sv
// Transmit-side PID encoder/serializer: shifts {~pid,pid} LSB-first, then forwards
// payload bits to the bit-stuffer and flags which CRC applies.
module pid_tx_block
  import pid_pkg::*;
#(
  parameter int unsigned MAX_PL_BITS = 8208,
  parameter int unsigned CNT_W       = 14
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] pkt_type,
  input  logic [1:0] pid_sel,
  input  logic       pl_valid,
  input  logic       pl_data,
  input  logic       pl_last,
  output logic       pl_ready,
  output logic       data_out,
  output logic       tx_en,
  output logic       busy,
  output logic       crc5_put,
  output logic       crc16_put,
  output logic       done,
  output logic       error
);

  pid_tx_state_e    r_state, w_state_n;
  logic [1:0]       r_type, w_type_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic             r_ovf, w_ovf_n;

  logic r_data_out, r_tx_en, r_busy, r_crc5, r_crc16, r_done, r_error;
  logic w_data_out, w_tx_en, w_busy, w_crc5, w_crc16, w_done, w_error;
  logic w_load, w_shift, w_bit, w_last, w_empty;

  pid_tx_piso u_piso (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (pid_byte(pkt_type, pid_sel)),
    .o_bit   (w_bit),
    .o_last  (w_last),
    .o_empty (w_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_type     <= PKT_ILLEGAL;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_data_out <= 1'b0;
      r_tx_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_crc5     <= 1'b0;
      r_crc16    <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_type     <= w_type_n;
      r_cnt      <= w_cnt_n;
      r_ovf      <= w_ovf_n;
      r_data_out <= w_data_out;
      r_tx_en    <= w_tx_en;
      r_busy     <= w_busy;
      r_crc5     <= w_crc5;
      r_crc16    <= w_crc16;
      r_done     <= w_done;
      r_error    <= w_error;
    end
  end

  // Next state plus the values the output registers take at the coming edge.
  always_comb begin
    w_state_n  = r_state;
    w_type_n   = r_type;
    w_cnt_n    = r_cnt;
    w_ovf_n    = r_ovf;
    w_load     = 1'b0;
    w_shift    = 1'b0;
    w_data_out = r_data_out;
    w_tx_en    = 1'b0;
    w_crc5     = 1'b0;
    w_crc16    = 1'b0;
    w_done     = 1'b0;
    w_error    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_n = '0;
        w_ovf_n = 1'b0;
        if (start) begin
          if (pkt_type != PKT_ILLEGAL) begin
            w_load    = 1'b1;
            w_type_n  = pkt_type;
            w_state_n = ST_SEND_PID;
          end else begin
            w_error = 1'b1;
          end
        end
      end
      ST_SEND_PID: begin
        w_shift    = !w_empty;
        w_tx_en    = !w_empty;
        w_data_out = w_bit;
        if (w_last || w_empty) begin
          w_state_n = (r_type == PKT_HANDSHAKE) ? ST_DONE : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        // Flags stay aligned with the payload bits they cover on data_out.
        w_crc5  = (r_type == PKT_TOKEN);
        w_crc16 = (r_type == PKT_DATA);
        if (pl_valid) begin
          w_data_out = pl_data;
          w_tx_en    = 1'b1;
          w_cnt_n    = r_cnt + CNT_W'(1);
          if (pl_last) begin
            w_state_n = ST_DONE;
          end else if (r_cnt == CNT_W'(MAX_PL_BITS - 1)) begin
            w_ovf_n   = 1'b1;
            w_state_n = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_done    = 1'b1;
        w_error   = r_ovf;
        w_state_n = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase

    w_busy = (w_state_n != ST_IDLE);
  end

  assign pl_ready  = (r_state == ST_PAYLOAD);
  assign data_out  = r_data_out;
  assign tx_en     = r_tx_en;
  assign busy      = r_busy;
  assign crc5_put  = r_crc5;
  assign crc16_put = r_crc16;
  assign done      = r_done;
  assign error     = r_error;

endmodule
